// File: rtl/soc_pkg.sv
//==============================================================================
// Module : soc_pkg
// Brief  : Shared UART types and constants for the SOC UART slice.
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package soc_pkg;

    localparam int SOC_CLK_HZ        = 100_000_000;
    localparam int UART_BAUD         = 115_200;
    localparam int UART_CLKS_PER_BIT = SOC_CLK_HZ / UART_BAUD;
    localparam int UART_DATA_W       = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/soc_uart_if.sv
//==============================================================================
// Module : soc_uart_if
// Brief  : CSR-side handshake bundle for soc_uart (master = CSR, slave = UART).
// Config : SOC_UART_PARITY_EN adds rx_par_err
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface soc_uart_if;
    import soc_pkg::*;

    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_start;
    logic                   tx_busy;
    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_ack;
    logic                   rx_frm_err;
    logic                   rx_overrun;
`ifdef SOC_UART_PARITY_EN
    logic                   rx_par_err;

    modport master (
        output tx_data, tx_start, rx_ack,
        input  tx_busy, rx_data, rx_valid, rx_frm_err, rx_overrun, rx_par_err
    );
    modport slave (
        input  tx_data, tx_start, rx_ack,
        output tx_busy, rx_data, rx_valid, rx_frm_err, rx_overrun, rx_par_err
    );
`else
    modport master (
        output tx_data, tx_start, rx_ack,
        input  tx_busy, rx_data, rx_valid, rx_frm_err, rx_overrun
    );
    modport slave (
        input  tx_data, tx_start, rx_ack,
        output tx_busy, rx_data, rx_valid, rx_frm_err, rx_overrun
    );
`endif

endinterface

`default_nettype wire

// File: rtl/soc_uart_rx.sv
//==============================================================================
// Module : soc_uart_rx
// Brief  : UART receiver: rxd synchroniser, RX FSM and valid/error flags.
// Config : SOC_UART_PARITY_EN adds a PARITY state and rx_par_err
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module soc_uart_rx
    import soc_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uart_rxd,
    input  logic                   rx_ack,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   rx_frm_err,
`ifdef SOC_UART_PARITY_EN
    output logic                   rx_par_err,
`endif
    output logic                   rx_overrun
);

    localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half     = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
    localparam logic [2:0]         c_bit_last = 3'(UART_DATA_W - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxd;

    uart_state_t            r_state, w_state;
    logic [c_cnt_w-1:0]     r_cnt, w_cnt;
    logic [2:0]             r_bit, w_bit;
    logic [UART_DATA_W-1:0] r_shift, w_shift;
    logic                   w_end;
    logic                   w_stop_ok, w_stop_bad, w_par_hit, w_update;

    logic [UART_DATA_W-1:0] r_rx_data;
    logic                   r_rx_valid, r_frm_err, r_overrun;

    assign w_rxd = r_sync[SYNC_STAGES-1];
    assign w_end = (r_cnt == c_last);

    always_comb begin
        w_state    = r_state;
        w_cnt      = w_end ? '0 : r_cnt + c_one;
        w_bit      = r_bit;
        w_shift    = r_shift;
        w_stop_ok  = 1'b0;
        w_stop_bad = 1'b0;
        w_par_hit  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt = '0;
                if (!w_rxd) w_state = START;
            end
            // Half a bit in: a line back high means the falling edge was noise.
            START: begin
                if (r_cnt == c_half) begin
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_state = w_rxd ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_end) begin
                    w_shift = {w_rxd, r_shift[UART_DATA_W-1:1]};
                    w_bit   = r_bit + 3'd1;
`ifdef SOC_UART_PARITY_EN
                    if (r_bit == c_bit_last) w_state = PARITY;
`else
                    if (r_bit == c_bit_last) w_state = STOP;
`endif
                end
            end
            PARITY: begin
                if (w_end) begin
                    w_par_hit = 1'b1;
                    w_state   = STOP;
                end
            end
            STOP: begin
                if (w_end) begin
                    w_stop_ok  = w_rxd;
                    w_stop_bad = !w_rxd;
                    w_state    = w_rxd ? IDLE : BREAK;
                end
            end
            BREAK: begin
                w_cnt = '0;
                if (w_rxd) w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

`ifdef SOC_UART_PARITY_EN
    logic r_par_bad, r_par_err, w_par_mis;

    assign w_par_mis  = (^r_shift) ^ w_rxd;
    assign w_update   = w_stop_ok & ~r_par_bad;
    assign rx_par_err = r_par_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bad <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_hit & w_par_mis;
            if (w_par_hit) r_par_bad <= w_par_mis;
        end
    end
`else
    assign w_update = w_stop_ok;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '1;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], uart_rxd};
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
        end
    end

    // An ack landing on the completion cycle consumes the old byte, so no overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_frm_err  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_frm_err <= w_stop_bad;
            r_overrun <= 1'b0;
            if (w_update) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                r_overrun  <= r_rx_valid & ~rx_ack;
            end else if (rx_ack) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rx_frm_err = r_frm_err;
    assign rx_overrun = r_overrun;

endmodule

`default_nettype wire

// File: rtl/soc_uart.sv
//==============================================================================
// Module : soc_uart
// Brief  : 8N1 UART engine behind the SOC CSR block; TX inline, RX sub-module.
// Config : SOC_UART_PARITY_EN selects 8E1 framing and exposes rx_par_err
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module soc_uart
    import soc_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    soc_uart_if.slave  csr,
    output logic       uart_txd,
    input  logic       uart_rxd
);

    localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
    localparam logic [2:0]         c_bit_last = 3'(UART_DATA_W - 1);

    uart_state_t            r_tx_state, w_tx_state;
    logic [c_cnt_w-1:0]     r_tx_cnt, w_tx_cnt;
    logic [2:0]             r_tx_bit, w_tx_bit;
    logic [UART_DATA_W-1:0] r_tx_shift, w_tx_shift;
    logic                   r_txd, w_txd;
    logic                   w_tx_end;
    logic                   r_tx_par, w_tx_par;

    assign w_tx_end = (r_tx_cnt == c_last);

    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_cnt   = w_tx_end ? '0 : r_tx_cnt + c_one;
        w_tx_bit   = r_tx_bit;
        w_tx_shift = r_tx_shift;
        w_tx_par   = r_tx_par;
        case (r_tx_state)
            IDLE: begin
                w_tx_cnt = '0;
                if (csr.tx_start) begin
                    w_tx_state = START;
                    w_tx_shift = csr.tx_data;
                    w_tx_bit   = '0;
                    w_tx_par   = ^csr.tx_data;
                end
            end
            START: begin
                if (w_tx_end) w_tx_state = DATA;
            end
            DATA: begin
                if (w_tx_end) begin
                    w_tx_shift = r_tx_shift >> 1;
                    w_tx_bit   = r_tx_bit + 3'd1;
`ifdef SOC_UART_PARITY_EN
                    if (r_tx_bit == c_bit_last) w_tx_state = PARITY;
`else
                    if (r_tx_bit == c_bit_last) w_tx_state = STOP;
`endif
                end
            end
            PARITY: begin
                if (w_tx_end) w_tx_state = STOP;
            end
            STOP: begin
                if (w_tx_end) w_tx_state = IDLE;
            end
            default: w_tx_state = IDLE;
        endcase

        // Line level follows the next state so uart_txd comes straight off a flop.
        w_txd = 1'b1;
        case (w_tx_state)
            START:   w_txd = 1'b0;
            DATA:    w_txd = w_tx_shift[0];
            PARITY:  w_txd = w_tx_par;
            default: w_txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_cnt   <= w_tx_cnt;
            r_tx_bit   <= w_tx_bit;
            r_tx_shift <= w_tx_shift;
            r_tx_par   <= w_tx_par;
            r_txd      <= w_txd;
        end
    end

    assign uart_txd    = r_txd;
    assign csr.tx_busy = (r_tx_state != IDLE);

    soc_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_rxd   (uart_rxd),
        .rx_ack     (csr.rx_ack),
        .rx_data    (csr.rx_data),
        .rx_valid   (csr.rx_valid),
        .rx_frm_err (csr.rx_frm_err),
`ifdef SOC_UART_PARITY_EN
        .rx_par_err (csr.rx_par_err),
`endif
        .rx_overrun (csr.rx_overrun)
    );

endmodule

`default_nettype wire

// File: doc/soc_uart.md
Name: soc_uart

Overview:
- 8N1 UART engine sitting directly downstream of the SOC CSR block.
- TX side consumes the CSR's uart_tx data byte and its uart_tx_start write-pulse.
- RX side produces the byte and valid flag that the CSR's uart_rx register reads back.
- Single clock domain; only the uart_rxd pin is asynchronous and is synchronised internally.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); legal range 4..65535
SYNC_STAGES, 2, flip-flop depth of the uart_rxd synchroniser; legal range 2..4

Ports:
clk  in  1  system clock; every flop is rising-edge
rst  in  1  synchronous, active-high reset
tx_data  in  8  byte to send (CSR uart_tx.data)
tx_start  in  1  one-cycle start pulse (CSR uart_tx_start.pulse)
tx_busy  out  1  frame in progress; tx_start is ignored while high
uart_txd  out  1  serial output; idles high
uart_rxd  in  1  asynchronous serial input
rx_data  out  8  last received byte (CSR uart_rx.data)
rx_valid  out  1  rx_data holds an unread byte (CSR uart_rx.valid)
rx_ack  in  1  one-cycle pulse that clears rx_valid
rx_frm_err  out  1  one-cycle pulse: stop bit sampled low
rx_overrun  out  1  one-cycle pulse: byte completed while rx_valid was already high

Behaviour:
- Reset values: uart_txd=1, tx_busy=0, rx_data=0, rx_valid=0, rx_frm_err=0, rx_overrun=0. Both FSMs go to IDLE, all counters clear, synchroniser flops load 1.
- Reset asserted mid-frame aborts the frame. uart_txd is 1 on the cycle after rst is sampled high.
- Bit counter counts 0..CLKS_PER_BIT-1; width is $clog2(CLKS_PER_BIT).
- TX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE & tx_start: latch tx_data into the shift register; tx_busy=1 and uart_txd=0 from the next cycle.
  - START: drives 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: drives 1 for CLKS_PER_BIT cycles, then tx_busy=0.
  - Total busy time is exactly 10*CLKS_PER_BIT cycles.
  - tx_start while busy is dropped; there is no queueing.
  - A tx_start in the same cycle that STOP completes is also dropped; tx_start is accepted only when the FSM is in IDLE.
- RX FSM states: IDLE -> START -> DATA -> STOP -> IDLE, plus a BREAK state.
  - IDLE: stays until the synchronised rxd is sampled 0.
  - START: waits CLKS_PER_BIT/2 cycles (integer division), then re-samples. If 1 it was a glitch: return to IDLE with no output. If 0, go to DATA.
  - DATA: samples every CLKS_PER_BIT cycles from mid-start; shifts 8 bits LSB first.
  - STOP: samples once at mid-stop.
    - Sample 1: rx_data <= shift register and rx_valid <= 1, both on the following cycle. If rx_valid was already 1 and rx_ack is not asserted this cycle, pulse rx_overrun for one cycle; the new byte overwrites.
    - Sample 0: rx_frm_err pulses for one cycle, rx_data and rx_valid are unchanged, FSM goes to BREAK.
  - BREAK: wait until rxd=1, then go to IDLE.
  - rx_ack clears rx_valid on the next cycle.
  - rx_ack in the same cycle as byte completion: rx_valid stays 1 with the new data; no overrun.
- TX and RX are fully independent; full duplex is supported.

Optional Feature:
- Macro: SOC_UART_PARITY_EN.
- Defined:
  - An even-parity bit is inserted after DATA, in a PARITY state in both FSMs. The TX frame becomes 11*CLKS_PER_BIT cycles.
  - RX checks parity. On mismatch it pulses an extra output port rx_par_err (1 bit) for one cycle and does not update rx_data or rx_valid; the STOP check still runs.
- Not defined: pure 8N1, no PARITY state and no rx_par_err port.

Decomposition:
- soc_pkg holds:
  - the uart_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - UART_DATA_W=8;
  - the default CLKS_PER_BIT constant derived from the SOC clock frequency and baud-rate constants.
- csr_pkg is untouched; the top-level wiring maps ports to the existing csr fields.
- One sub-module: soc_uart_rx holds the synchroniser, RX FSM and RX flags. TX stays inline in soc_uart.

Test Plan (bench uses CLKS_PER_BIT=16):
- Reset: hold rst for 3 cycles with uart_rxd=0 -> uart_txd=1, tx_busy=0, rx_valid=0, no error pulses.
- TX 0xA5: one tx_start pulse -> uart_txd=0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles; tx_busy high for exactly 160 cycles. A second tx_start at cycle 50 has no effect.
- RX 0x3C then loopback: drive frame 0x3C -> rx_data=0x3C, rx_valid=1 one cycle after mid-stop. rx_ack -> rx_valid=0 next cycle. Then loop uart_txd into uart_rxd while sending 0x81 -> rx_data=0x81.
- Overrun and simultaneous ack:
  - Receive 0x11 then 0x22 with no ack -> one rx_overrun pulse, rx_data=0x22.
  - Repeat with rx_ack asserted on the completion cycle -> no rx_overrun, rx_valid=1.
- Framing and glitch:
  - Frame 0x55 with stop bit driven 0 -> one rx_frm_err pulse, rx_data unchanged; no new start is accepted until rxd returns to 1.
  - A 5-cycle low glitch -> no output.
- Reset mid-TX: assert rst at cycle 70 of a frame -> uart_txd=1 and tx_busy=0 on the next cycle; a fresh tx_start afterwards gives a clean 160-cycle frame.
